div_controller: RTL and testbench

- Sequencing FSM for the restoring-division datapath: 8-bit dividend, 7-bit divisor, 16-bit shift/remainder register.
- Accepts a start request, then drives the datapath controls `load`, `add`, `shift`, `inbit` and `sel` for one load cycle and N_BITS iteration cycles.
- Reads the datapath `sign` each iteration and signals completion.
- Sits between the top-level handshake and the datapath. Quotient and remainder are read directly from the datapath outputs.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_controller.sv | 123 ++++++++++++
 tb/tb_div_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the restoring-division controller
//
// Contents:
//   state_t        - controller states IDLE, LOAD, ITER, DONE
//   SEL_*          - datapath mux select codes (00 is never driven)
//   DEFAULT_N_BITS - default iteration count (dividend width)

package div_pkg;

  localparam int DEFAULT_N_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_ADDER    = 2'b01;
  localparam logic [1:0] SEL_DIVIDEND = 2'b10;
  localparam logic [1:0] SEL_HOLD     = 2'b11;

endpackage

// File: rtl/div_controller.sv
// rtl/div_controller.sv - sequencing FSM for the restoring-division datapath
//
// Runs one LOAD cycle and N_BITS ITER cycles per divide, then a one-cycle
// DONE pulse. Quotient and remainder are read straight from the datapath.
//
// Optional build macro: DIV_CONTROLLER_ABORT_EN adds the abort input.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   begin a divide (sampled only in IDLE)
//   abort  in   (DIV_CONTROLLER_ABORT_EN only) cancel from LOAD/ITER
//   sign   in   datapath adder-result MSB (1 = R_hi - divisor < 0)
//   load   out  divisor-register load enable
//   add    out  adder mode (1 = add, 0 = subtract); always subtract here
//   shift  out  shift-left enable
//   inbit  out  bit shifted into R[0] (next quotient bit)
//   sel    out  datapath mux select: 01 adder, 10 dividend, 11 hold
//   busy   out  high in every state except IDLE
//   done   out  one-cycle completion pulse

module div_controller
  import div_pkg::*;
#(
  parameter int N_BITS = DEFAULT_N_BITS,
  parameter int CNT_W  = $clog2(N_BITS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef DIV_CONTROLLER_ABORT_EN
  input  logic       abort,
`endif
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;

  // State and iteration counter. The counter is cleared while in LOAD so it
  // reads 0 in the first ITER cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == LOAD) begin
        count <= '0;
      end else if (state == ITER) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Next-state and outputs. Everything is Moore on state except sel/inbit in
  // ITER, which follow sign: a non-negative difference is written back and a
  // 1 shifted in; a negative one is discarded (restore) and a 0 shifted in.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    add        = 1'b0;
    shift      = 1'b0;
    inbit      = 1'b0;
    sel        = SEL_HOLD;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        sel        = SEL_DIVIDEND;
        shift      = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        shift = 1'b1;
        if (!sign) begin
          sel   = SEL_ADDER;
          inbit = 1'b1;
        end
        if (count == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef DIV_CONTROLLER_ABORT_EN
    // Abort wins over the terminal count; the datapath is left untouched.
    if (abort && (state == LOAD || state == ITER)) begin
      state_next = IDLE;
      load       = 1'b0;
      shift      = 1'b0;
      inbit      = 1'b0;
      sel        = SEL_HOLD;
    end
`endif
  end

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - bench for div_controller driving a behavioural restoring-division datapath
module tb_div_controller;

  localparam logic [1:0] HOLD = 2'b11;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       sign;
  logic       load;
  logic       add;
  logic       shift;
  logic       inbit;
  logic [1:0] sel;
  logic       busy;
  logic       done;

  logic [7:0]  dividend;
  logic [6:0]  divisor;
  logic [15:0] r;
  logic [6:0]  dreg;
  logic [8:0]  diff;
  logic [15:0] mux;

  int vectors;
  int miscompares;
  int sel00_seen;

  div_controller dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef DIV_CONTROLLER_ABORT_EN
    .abort (abort),
`endif
    .sign  (sign),
    .load  (load),
    .add   (add),
    .shift (shift),
    .inbit (inbit),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath: divisor register, 16-bit shift/remainder register, subtractor.
  assign diff = {1'b0, r[15:8]} - {2'b00, dreg};
  assign sign = diff[8];

  always_comb begin
    mux = r;
    case (sel)
      2'b01:   mux = {diff[7:0], r[7:0]};
      2'b10:   mux = {8'h00, dividend};
      default: mux = r;
    endcase
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r    <= 16'h0000;
      dreg <= 7'h00;
    end else begin
      if (load) dreg <= divisor;
      r <= shift ? {mux[14:0], inbit} : mux;
    end
  end

  always @(negedge clk) begin
    if (!reset && sel == 2'b00) sel00_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One divide from IDLE. Cycle index 1 is the cycle after the start edge;
  // glitch_idx > 0 pulses start for one cycle at that index.
  task automatic run_div(input logic [7:0] a, input logic [6:0] d, input int glitch_idx);
    int first_done;
    int n_done;
    int n_zero_bits;
    logic [7:0] q_exp;
    logic [6:0] rem_exp;
    dividend = a;
    divisor  = d;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    first_done  = 0;
    n_done      = 0;
    n_zero_bits = 0;
    for (int idx = 1; idx <= 14; idx++) begin
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = idx;
      end
      if (sel == HOLD && shift) n_zero_bits++;
      start = (glitch_idx != 0 && idx == glitch_idx);
      @(negedge clk);
    end
    start   = 1'b0;
    q_exp   = (d == 0) ? 8'hFF : 8'(a / d);
    rem_exp = (d == 0) ? 7'(a) : 7'(a % d);
    chk($sformatf("latency %0d/%0d", a, d), 32'(first_done), 32'd10);
    chk($sformatf("done_count %0d/%0d", a, d), 32'(n_done), 32'd1);
    chk($sformatf("quotient %0d/%0d", a, d), 32'(r[7:0]), 32'(q_exp));
    if (d != 0) begin
      chk($sformatf("remainder %0d/%0d", a, d), 32'(r[15:9]), 32'(rem_exp));
      chk($sformatf("restore_cycles %0d/%0d", a, d), 32'(n_zero_bits),
          32'(8 - $countones(q_exp)));
    end
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    int done_at [3];
    vectors     = 0;
    miscompares = 0;
    sel00_seen  = 0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    dividend = 8'h00;
    divisor  = 7'h00;
    repeat (3) @(negedge clk);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_add", 32'(add), 32'd0);
    chk("rst_shift", 32'(shift), 32'd0);
    chk("rst_inbit", 32'(inbit), 32'd0);
    chk("rst_sel", 32'(sel), 32'(HOLD));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_div(8'd100, 7'd7, 0);
    run_div(8'd255, 7'd1, 0);
    run_div(8'd5, 7'd9, 0);
    run_div(8'd0, 7'd3, 0);
    run_div(8'd77, 7'd0, 0);

    // Reset in the 4th ITER cycle (cycle index 5).
    dividend = 8'd100;
    divisor  = 7'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sel", 32'(sel), 32'(HOLD));
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    run_div(8'd100, 7'd7, 0);

    // Start pulsed in the 3rd ITER cycle (index 4) is ignored.
    run_div(8'd100, 7'd7, 4);

    // Continuous start: done every 11 cycles.
    dividend = 8'd200;
    divisor  = 7'd13;
    start  = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int idx = 1; idx <= 40 && n_done < 3; idx++) begin
      @(negedge clk);
      if (done) begin
        done_at[n_done] = idx;
        chk("b2b_quotient", 32'(r[7:0]), 32'd15);
        chk("b2b_remainder", 32'(r[15:9]), 32'd5);
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
    end
    chk("b2b_count", 32'(n_done), 32'd3);
    if (n_done == 3) begin
      chk("b2b_first", 32'(done_at[0]), 32'd10);
      chk("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd11);
      chk("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd11);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

`ifdef DIV_CONTROLLER_ABORT_EN
    // Abort in the 2nd ITER cycle (index 3).
    dividend = 8'd100;
    divisor  = 7'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_sel", 32'(sel), 32'(HOLD));
    chk("abort_shift", 32'(shift), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run_div(8'd100, 7'd7, 0);
`endif

    // Randomized operands against plain integer division.
    for (int i = 0; i < 20; i++) begin
      run_div(8'($urandom_range(0, 255)), 7'($urandom_range(1, 127)), 0);
    end
    run_div(8'($urandom_range(0, 255)), 7'd0, 0);

    chk("sel_never_00", 32'(sel00_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
